// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side packer: FSM states, lane counter width, beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_pkg;

    // Beat geometry; the top-level DATA_W/PACK parameters default to these and must match them.
    localparam int unsigned PKG_DATA_W = 8;
    localparam int unsigned PKG_PACK   = 2;

    // Lane index width, never narrower than one bit so PACK=1 still has a legal counter.
    function automatic int unsigned lane_w(input int unsigned pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    localparam int unsigned LANE_W = lane_w(PKG_PACK);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FL_WAIT = 2'd1,
        FL_EMIT = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKG_PACK*PKG_DATA_W-1:0] data;
        logic [PKG_PACK-1:0]            keep;
    } beat_t;

endpackage

// File: rtl/fifo_rd_oq.sv
// Two-entry valid/ready output queue holding packed beats.
// Latency: one cycle from write to rd_valid; head is read straight from storage.
// Backpressure: rd_ready low holds the head stable; the writer must respect cnt (no overflow).
module fifo_rd_oq
    import fifo_rd_pkg::*;
(
    input  logic       rclk,
    input  logic       rrst_n,
    input  logic       wr_en,
    input  beat_t      wr_beat,
    output logic       rd_valid,
    input  logic       rd_ready,
    output beat_t      rd_beat,
    output logic [1:0] cnt
);

    beat_t      mem_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       rd_fire;

    assign rd_valid = (cnt_q != 2'd0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_beat  = mem_q[rptr_q];
    assign cnt      = cnt_q;

    // Occupancy after this cycle's write and read; write+read together leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q + {1'b0, wr_en} - {1'b0, rd_fire};
    end

    // Storage and pointers; a write into a full queue lands in the slot being read out this cycle.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q] <= wr_beat;
                wptr_q        <= ~wptr_q;
            end
            if (rd_fire) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(wr_en && (cnt_q == 2'd2) && !rd_fire));

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the dual-clock FIFO, packs PACK words per beat and streams beats out; flush emits a partial beat.
// Latency: beat becomes valid two cycles after the pop of its last word (registered rdata + queue).
// Backpressure: m_ready low fills the 2-entry queue, after which pops stop; data held while stalled.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = PKG_DATA_W,
    parameter int unsigned PACK   = PKG_PACK,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                fifo_rempty,
    input  logic [DATA_W-1:0]   fifo_rdata,
    output logic                fifo_rinc,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [PACK*DATA_W-1:0] m_data,
    output logic [PACK-1:0]     m_keep,
    input  logic                flush,
    output logic                flush_done,
    output logic [CNT_W-1:0]    beat_cnt
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

    state_e              state_q, state_d;
    logic                pend_q;
    logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [DATA_W-1:0]   lanes_q [PACK];
    logic [CNT_W-1:0]    beat_cnt_q;

    beat_t               wr_beat;
    beat_t               oq_head;
    logic                oq_vld;
    logic [1:0]          oq_cnt;
    logic                wr_en;
    logic                comp;
    logic                emit;
    logic                deq;
    logic [2:0]          occ;

    assign deq  = oq_vld && m_ready;
    assign comp = pend_q && (lane_cnt_q == LAST_LANE);
    // Queue occupancy as it will be once the in-flight word (if it completes a beat) lands.
    assign occ  = {1'b0, oq_cnt} + {2'b0, comp} - {2'b0, deq};
    assign emit = (state_q == FL_EMIT) && (({1'b0, oq_cnt} - {2'b0, deq}) <= 3'd1);
    assign wr_en = comp || emit;

    // Pop is combinational from m_ready/rempty so a full queue that is draining can still refill.
    assign fifo_rinc = rrst_n && !fifo_rempty && (state_q == RUN) && !flush && (occ <= 3'd1);

    assign m_valid    = oq_vld;
    assign m_data     = oq_head.data;
    assign m_keep     = oq_head.keep;
    assign beat_cnt   = beat_cnt_q;

    // Beat going into the queue: full beat includes this cycle's rdata; partial beat zeroes unfilled lanes.
    always_comb begin
        wr_beat = '0;
        for (int i = 0; i < PACK; i++) begin
            if (comp) begin
                wr_beat.data[i*DATA_W +: DATA_W] = (lane_cnt_q == LANE_W'(i)) ? fifo_rdata : lanes_q[i];
                wr_beat.keep[i]                  = 1'b1;
            end else if (LANE_W'(i) < lane_cnt_q) begin
                wr_beat.data[i*DATA_W +: DATA_W] = lanes_q[i];
                wr_beat.keep[i]                  = 1'b1;
            end
        end
    end

    // Lane counter: advance per captured word, wrap on a full beat, clear after a partial emit.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        if (comp) begin
            lane_cnt_d = '0;
        end else if (pend_q) begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
        end
        if (emit) begin
            lane_cnt_d = '0;
        end
    end

    // Flush sequencing: wait for the in-flight word, emit any partial beat, then pulse done.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) state_d = FL_WAIT;
            end
            FL_WAIT: begin
                if (!pend_q) state_d = (lane_cnt_q == '0) ? DONE : FL_EMIT;
            end
            FL_EMIT: begin
                if (emit) state_d = DONE;
            end
            DONE: begin
                flush_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Datapath and control registers; rdata is only sampled the cycle after a pop.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= RUN;
            pend_q     <= 1'b0;
            lane_cnt_q <= '0;
            beat_cnt_q <= '0;
            for (int i = 0; i < PACK; i++) lanes_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= fifo_rinc;
            lane_cnt_q <= lane_cnt_d;
            if (pend_q) lanes_q[lane_cnt_q] <= fifo_rdata;
            if (deq) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    fifo_rd_oq u_oq (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .wr_en    (wr_en),
        .wr_beat  (wr_beat),
        .rd_valid (oq_vld),
        .rd_ready (m_ready),
        .rd_beat  (oq_head),
        .cnt      (oq_cnt)
    );

endmodule
